// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer and its synchroniser.
// Latency: n/a; backpressure: n/a.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        SYNC,
        HOLD,
        RELEASE,
        RUN,
        PULSE
    } seq_state_t;

    localparam int SYNC_DEPTH = 2;
    localparam int RCNT_W     = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchroniser.
// Latency: DEPTH clock edges on deassertion, none on assertion; backpressure: none.
module reset_sync
    import reset_seq_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], 1'b1};
        end
    end

    assign rst_n_sync = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset release with software and watchdog re-reset pulses.
// Latency: ch0 free 3+HOLD_CYCLES edges after Reset rises; backpressure: none, sw_req dropped outside RUN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int HOLD_CYCLES    = 2,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              sw_req,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  pulse_len,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              busy,
    output logic              seq_done,
    output logic [RCNT_W-1:0] reset_count
);

    // Shared down-counter must hold the larger of the pulse length and the fixed delays.
    localparam int DW  = max_int(CNT_W, max_int($clog2(HOLD_CYCLES + 1), $clog2(STAGGER_CYCLES + 1)));
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [DW-1:0]  HOLD_LD = DW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0]  STAG_LD = DW'(STAGGER_CYCLES - 1);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

    seq_state_t        state, state_nxt;
    logic [DW-1:0]     cnt, cnt_nxt;
    logic [CHW-1:0]    ch, ch_nxt;
    logic [NUM_CH-1:0] rst_q, rst_nxt;
    logic              done_q, done_nxt;
    logic [CNT_W-1:0]  pcnt, pcnt_nxt;
    logic [RCNT_W-1:0] rcnt, rcnt_nxt;
    logic              sync_n;
    logic              trigger;

    reset_sync #(
        .DEPTH(SYNC_DEPTH)
    ) u_sync (
        .clk       (CLK),
        .rst_n     (Reset),
        .rst_n_sync(sync_n)
    );

    // Period is compared live so a reprogrammed value takes effect immediately.
    assign trigger = sw_req || ((period != '0) && (pcnt == (period - CNT_W'(1))));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state  <= SYNC;
            cnt    <= '0;
            ch     <= '0;
            rst_q  <= '0;
            done_q <= 1'b0;
            pcnt   <= '0;
            rcnt   <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ch     <= ch_nxt;
            rst_q  <= rst_nxt;
            done_q <= done_nxt;
            pcnt   <= pcnt_nxt;
            rcnt   <= rcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch;
        rst_nxt   = rst_q;
        done_nxt  = 1'b0;
        pcnt_nxt  = pcnt;
        rcnt_nxt  = rcnt;
        case (state)
            SYNC: begin
                rst_nxt = '0;
                if (sync_n) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt  = RELEASE;
                    rst_nxt[0] = 1'b1;
                    cnt_nxt    = STAG_LD;
                    ch_nxt     = CHW'(1);
                    if (NUM_CH == 1) begin
                        done_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - DW'(1);
                end
            end
            RELEASE: begin
                if (NUM_CH == 1) begin
                    state_nxt = RUN;
                    pcnt_nxt  = '0;
                end else if (cnt == '0) begin
                    rst_nxt[ch] = 1'b1;
                    cnt_nxt     = STAG_LD;
                    ch_nxt      = ch + CHW'(1);
                    if (ch == LAST_CH) begin
                        done_nxt  = 1'b1;
                        state_nxt = RUN;
                        pcnt_nxt  = '0;
                    end
                end else begin
                    cnt_nxt = cnt - DW'(1);
                end
            end
            RUN: begin
                pcnt_nxt = pcnt + CNT_W'(1);
                if (trigger) begin
                    state_nxt = PULSE;
                    rst_nxt   = '0;
                    // A zero length still yields a single-cycle pulse.
                    cnt_nxt   = (pulse_len == '0) ? '0 : (DW'(pulse_len) - DW'(1));
                    if (rcnt != {RCNT_W{1'b1}}) begin
                        rcnt_nxt = rcnt + RCNT_W'(1);
                    end
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - DW'(1);
                end
            end
            default: begin
                state_nxt = SYNC;
                rst_nxt   = '0;
            end
        endcase
    end

    assign rst_n_out   = rst_q;
    assign busy        = (state != RUN);
    assign seq_done    = done_q;
    assign reset_count = rcnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, sw/watchdog re-reset, saturation, mid-sequence aborts.
module tb_reset_sequencer;

    localparam int NUM_CH  = 3;
    localparam int HOLD    = 2;
    localparam int STAGGER = 4;
    localparam int CNT_W   = 16;

    logic              CLK;
    logic              Reset;
    logic              sw_req;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  pulse_len;
    logic [NUM_CH-1:0] rst_n_out;
    logic              busy;
    logic              seq_done;
    logic [7:0]        reset_count;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .NUM_CH        (NUM_CH),
        .HOLD_CYCLES   (HOLD),
        .STAGGER_CYCLES(STAGGER),
        .CNT_W         (CNT_W)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .sw_req     (sw_req),
        .period     (period),
        .pulse_len  (pulse_len),
        .rst_n_out  (rst_n_out),
        .busy       (busy),
        .seq_done   (seq_done),
        .reset_count(reset_count)
    );

    // First rising edge at 10 ns so the 35 ns release never races a clock edge.
    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks the release sequence; c0 is the edge (counted from now) on which channel 0 frees.
    task automatic run_seq(input int c0, input int req_k, input int exp_cnt, input string tag);
        int last;
        logic [NUM_CH-1:0] e;
        last = c0 + STAGGER * (NUM_CH - 1);
        for (int k = 1; k <= last; k++) begin
            @(posedge CLK);
            #1;
            e = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (k >= c0 + STAGGER * i) e[i] = 1'b1;
            end
            chk($sformatf("%s_rst_k%0d", tag, k), 32'(rst_n_out), 32'(e));
            chk($sformatf("%s_done_k%0d", tag, k), 32'(seq_done), 32'(k == last));
            chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'(k < last));
            sw_req = (k == req_k);
        end
        chk($sformatf("%s_count", tag), 32'(reset_count), 32'(exp_cnt));
    endtask

    task automatic do_sw(input int exp_cnt, input string tag);
        sw_req = 1'b1;
        @(posedge CLK);
        #1;
        sw_req = 1'b0;
        chk($sformatf("%s_rst", tag), 32'(rst_n_out), 32'd0);
        chk($sformatf("%s_busy", tag), 32'(busy), 32'd1);
        chk($sformatf("%s_count", tag), 32'(reset_count), 32'(exp_cnt));
    endtask

    // Expects rst_n_out to stay high for n-1 edges and fall on edge n.
    task automatic wait_pulse(input int n, input int exp_cnt, input string tag);
        for (int k = 1; k <= n; k++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("%s_rst_k%0d", tag, k), 32'(rst_n_out),
                (k < n) ? 32'((1 << NUM_CH) - 1) : 32'd0);
        end
        chk($sformatf("%s_count", tag), 32'(reset_count), 32'(exp_cnt));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset     = 1'b0;
        sw_req    = 1'b0;
        period    = '0;
        pulse_len = 16'd3;

        #20;
        chk("rst_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_seq_done", 32'(seq_done), 32'd0);
        chk("rst_count", 32'(reset_count), 32'd0);
        #15;
        Reset = 1'b1;
        run_seq(3 + HOLD, 0, 0, "pwrup");

        // Software pulse, then a request during RELEASE that must be dropped.
        do_sw(1, "sw");
        run_seq(3 + HOLD, 7, 1, "sw_seq");

        period = 16'd10;
        wait_pulse(10, 2, "wd1");
        run_seq(3 + HOLD, 0, 2, "wd1_seq");
        wait_pulse(10, 3, "wd2");
        run_seq(3 + HOLD, 0, 3, "wd2_seq");

        // sw_req lands on the timer-expiry cycle.
        idle(9);
        chk("coin_pre_rst", 32'(rst_n_out), 32'((1 << NUM_CH) - 1));
        do_sw(4, "coin");
        run_seq(3 + HOLD, 0, 4, "coin_seq");

        period = '0;
        idle(25);
        chk("off_rst", 32'(rst_n_out), 32'((1 << NUM_CH) - 1));
        chk("off_busy", 32'(busy), 32'd0);
        chk("off_count", 32'(reset_count), 32'd4);

        pulse_len = '0;
        do_sw(5, "len0");
        run_seq(1 + HOLD, 0, 5, "len0_seq");

        // Back-to-back auto pulses, far more than 255 of them.
        period = 16'd1;
        idle(4000);
        chk("sat_count", 32'(reset_count), 32'd255);
        period = '0;
        idle(20);
        chk("sat_hold_count", 32'(reset_count), 32'd255);

        pulse_len = 16'd3;
        do_sw(255, "sat_sw");
        idle(6);
        chk("abort_rel_pre", 32'(rst_n_out), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_rel_rst", 32'(rst_n_out), 32'd0);
        chk("abort_rel_done", 32'(seq_done), 32'd0);
        chk("abort_rel_busy", 32'(busy), 32'd1);
        chk("abort_rel_count", 32'(reset_count), 32'd0);
        @(posedge CLK);
        #4;
        Reset = 1'b1;
        run_seq(3 + HOLD, 0, 0, "repwr1");

        do_sw(1, "abort_pulse_sw");
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_pulse_rst", 32'(rst_n_out), 32'd0);
        chk("abort_pulse_busy", 32'(busy), 32'd1);
        chk("abort_pulse_count", 32'(reset_count), 32'd0);
        @(posedge CLK);
        #4;
        Reset = 1'b1;
        run_seq(3 + HOLD, 0, 0, "repwr2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
